rx_ext_ts: RTL and testbench
============================

Name: rx_ext_ts

Overview:
- Extracts the ingress timestamp nanoseconds that the RX embed stage writes into the 4-octet messageTypeSpecific field of received PTPv2 event messages.
- Rebuilds the full 80-bit ingress time (48-bit s + 32-bit ns) against the live RTC and pushes {messageType, sequenceId, timestamp} into a timestamp FIFO for host/CPU readout.
- Sits on the XGMII RX path directly after the RX embed stage and passes data through with fixed latency.

Parameters:
- FIFO_DEPTH, 8, timestamp FIFO entries (power of 2, 2..64).
- FIFO_AW, 3, log2(FIFO_DEPTH).

Ports:
- rx_clk  in  1  RX clock.
- rx_rst_n  in  1  async active-low reset.
- rx_clk_en_i  in  1  clock enable for GMII/MII adaptation; all state advances only when high.
- rxd_i  in  64  XGMII data, lane i = bits 8i+7:8i.
- rxc_i  in  8  XGMII control, one bit per lane.
- rxd_o  out  64  pass-through data, 1 enabled-cycle latency.
- rxc_o  out  8  pass-through control, 1 enabled-cycle latency.
- rtc_time_i  in  80  live RTC {48 s, 32 ns}.
- tsu_cfg_i  in  32  config; bit5 = emb_ingressTime_en.
- eth_count_i  in  11  byte count of lane 0, aligned with rxd_i.
- ptp_addr_base_i  in  11  byte offset of PTP header start.
- ptp_messageType_i  in  4  parsed messageType.
- is_ptp_message_i  in  1  frame is PTP.
- ts_rd_en_i  in  1  FIFO pop strobe.
- ts_empty_o  out  1  FIFO empty.
- ts_data_o  out  100  head entry {messageType[3:0], sequenceId[15:0], sec[47:0], ns[31:0]}.
- ts_level_o  out  FIFO_AW+1  entry count.
- ts_drop_cnt_o  out  16  saturating count of entries dropped on FIFO full.

Behaviour:
- Reset values: rxd_o=0, rxc_o=0, ts_empty_o=1, ts_data_o=0, ts_level_o=0, ts_drop_cnt_o=0, FSM=IDLE, FIFO pointers=0.
- Qualification:
  - capture_en = tsu_cfg_i[5] & is_ptp_message_i & ~ptp_messageType_i[3].
  - Upstream holds type/base/is_ptp stable from header byte 4 until the terminate character.
- Byte match: lane i, byte offset = eth_count_i + i, data lanes only (rxc_i[i]=0).
  - Offsets base+16..+19 give ns, big-endian, MSB first.
  - Offsets base+30..+31 give sequenceId.
- FSM:
  - IDLE: go to HDR on a start control (lane0 rxc=1, data 0xFB). Clear the byte-valid mask.
  - HDR: collect bytes into the shadow register and set a 6-bit mask. When the mask is full and capture_en=1, go to WAIT_EOF. If a terminate arrives first, or capture_en=0, go to IDLE with no push.
  - WAIT_EOF: on a terminate (0xFD on any control lane), go to PUSH. On an error control (0xFE) on any lane, go to IDLE with no push.
  - PUSH: one cycle. Write the entry if the FIFO is not full; otherwise increment ts_drop_cnt_o, saturating at 0xFFFF. Go to IDLE.
  - Start control seen in any non-IDLE state: abort the current frame and re-enter HDR.
- Seconds reconstruction, sampled in PUSH:
  - sec = rtc_sec when ns_cap <= rtc_ns, else rtc_sec − 1 (48-bit, wraps modulo 2^48).
  - A frame arriving less than 1 s ago is guaranteed.
- FIFO:
  - Synchronous, first-word-fall-through; ts_data_o shows the head while not empty.
  - A pop when empty is ignored.
  - Push and pop in the same cycle when full: pop succeeds, push succeeds, no drop.
  - Push and pop in the same cycle when empty: push lands, level=1.
- Pointers wrap modulo FIFO_DEPTH. ts_level_o = wr−rd using an extra wrap bit.
- ts_rd_en_i is honoured regardless of rx_clk_en_i.
- Reset asserted mid-frame: FSM, FIFO, and counter clear immediately; the partial frame is discarded.

Optional Feature:
- Macro RX_EXT_TS_CLEAR_EN.
- Defined: on qualified frames, the rxd_o bytes at base+16..+19 are forced to 0x00, restoring the messageTypeSpecific field to its reserved value. Only valid for IPv4/UDP with checksum 0 or L2 transport.
- Undefined: rxd_o/rxc_o are a pure 1-cycle register of rxd_i/rxc_i.

Test Plan:
- Sync (type 0), ns=0x1234_5678 at base+16, seqId=0x00A5, rtc={s=100, ns=0x2000_0000} -> one entry {0, 0x00A5, 100, 0x12345678}, ts_empty_o falls 1 cycle after PUSH.
- Same frame with rtc ns=0x0000_0100 (wrapped) -> sec=99.
- Follow_Up (type 8), or tsu_cfg_i[5]=0 -> no entry, level stays 0.
- FIFO_DEPTH+2 frames, no reads -> level=8, ts_drop_cnt_o=2; first read returns first frame's seqId.
- Frame ends with 0xFE after header -> no push; next good frame pushes normally.
- With RX_EXT_TS_CLEAR_EN: rxd_o bytes base+16..19 = 0; all other bytes match rxd_i delayed 1 cycle. Without the macro, output is bit-identical to the input delayed 1 cycle.

Source files
------------

// File: rtl/rx_ext_ts_if.sv
// Bundle of the XGMII RX stream, parser sideband, RTC and timestamp FIFO readout for rx_ext_ts.
// Latency: none, this is wiring only.
// Backpressure: none; the stream free-runs and the FIFO side is a plain pop strobe.
interface rx_ext_ts_if #(
  parameter int FIFO_AW = 3
);
  logic             rx_clk_en_i;
  logic [63:0]      rxd_i;
  logic [7:0]       rxc_i;
  logic [63:0]      rxd_o;
  logic [7:0]       rxc_o;
  logic [79:0]      rtc_time_i;
  logic [31:0]      tsu_cfg_i;
  logic [10:0]      eth_count_i;
  logic [10:0]      ptp_addr_base_i;
  logic [3:0]       ptp_messageType_i;
  logic             is_ptp_message_i;
  logic             ts_rd_en_i;
  logic             ts_empty_o;
  logic [99:0]      ts_data_o;
  logic [FIFO_AW:0] ts_level_o;
  logic [15:0]      ts_drop_cnt_o;

  // Upstream / host side
  modport master (
    output rx_clk_en_i, rxd_i, rxc_i, rtc_time_i, tsu_cfg_i, eth_count_i,
           ptp_addr_base_i, ptp_messageType_i, is_ptp_message_i, ts_rd_en_i,
    input  rxd_o, rxc_o, ts_empty_o, ts_data_o, ts_level_o, ts_drop_cnt_o
  );

  // Extractor side
  modport slave (
    input  rx_clk_en_i, rxd_i, rxc_i, rtc_time_i, tsu_cfg_i, eth_count_i,
           ptp_addr_base_i, ptp_messageType_i, is_ptp_message_i, ts_rd_en_i,
    output rxd_o, rxc_o, ts_empty_o, ts_data_o, ts_level_o, ts_drop_cnt_o
  );
endinterface

// File: rtl/rx_ext_ts.sv
// Pulls embedded ingress ns + sequenceId from PTP event frames, rebuilds seconds from the RTC, queues entries.
// Latency: XGMII pass-through 1 enabled cycle; entry visible 1 cycle after the PUSH state.
// Backpressure: none; a full FIFO drops the entry and bumps a saturating counter. Optional RX_EXT_TS_CLEAR_EN zeroes the field.
module rx_ext_ts #(
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = 3
) (
  input logic        rx_clk,
  input logic        rx_rst_n,
  rx_ext_ts_if.slave bus
);
  typedef enum logic [1:0] {IDLE, HDR, WAIT_EOF, PUSH} state_t;

  state_t      state;
  logic [5:0]  mask;
  logic [31:0] ns_cap;
  logic [15:0] seq_cap;
  logic [3:0]  type_cap;

  logic [10:0] rel [8];
  logic        is_start, is_term, is_err, capture_en, mask_full;
  logic [5:0]  hit;
  logic [31:0] ns_nxt;
  logic [15:0] seq_nxt;
  logic [63:0] rxd_nxt;
  logic [47:0] sec;

  logic [99:0]      mem [FIFO_DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr, level;
  logic             full, empty, pop, push_req, push;
  logic [15:0]      drop_cnt;
  logic             unused_cfg;

  // Byte offset of each lane relative to the PTP header start
  for (genvar g = 0; g < 8; g++) begin : g_lane
    assign rel[g] = bus.eth_count_i + 11'(g) - bus.ptp_addr_base_i;
  end

  assign is_start   = bus.rxc_i[0] && (bus.rxd_i[7:0] == 8'hFB);
  assign capture_en = bus.tsu_cfg_i[5] & bus.is_ptp_message_i & ~bus.ptp_messageType_i[3];
  assign mask_full  = &(mask | hit);
  assign unused_cfg = ^{bus.tsu_cfg_i[31:6], bus.tsu_cfg_i[4:0]};

  // Lane decode: control characters and header bytes of interest in this word
  always_comb begin
    is_term = 1'b0;
    is_err  = 1'b0;
    hit     = '0;
    ns_nxt  = ns_cap;
    seq_nxt = seq_cap;
    for (int i = 0; i < 8; i++) begin
      if (bus.rxc_i[i]) begin
        if (bus.rxd_i[8*i +: 8] == 8'hFD) is_term = 1'b1;
        if (bus.rxd_i[8*i +: 8] == 8'hFE) is_err = 1'b1;
      end else begin
        case (rel[i])
          11'd16:  begin ns_nxt[31:24] = bus.rxd_i[8*i +: 8]; hit[0] = 1'b1; end
          11'd17:  begin ns_nxt[23:16] = bus.rxd_i[8*i +: 8]; hit[1] = 1'b1; end
          11'd18:  begin ns_nxt[15:8]  = bus.rxd_i[8*i +: 8]; hit[2] = 1'b1; end
          11'd19:  begin ns_nxt[7:0]   = bus.rxd_i[8*i +: 8]; hit[3] = 1'b1; end
          11'd30:  begin seq_nxt[15:8] = bus.rxd_i[8*i +: 8]; hit[4] = 1'b1; end
          11'd31:  begin seq_nxt[7:0]  = bus.rxd_i[8*i +: 8]; hit[5] = 1'b1; end
          default: ;
        endcase
      end
    end
  end

`ifdef RX_EXT_TS_CLEAR_EN
  // Restore messageTypeSpecific to zero on qualified frames while the header streams past
  always_comb begin
    rxd_nxt = bus.rxd_i;
    for (int i = 0; i < 8; i++) begin
      if (state == HDR && capture_en && !bus.rxc_i[i] && rel[i] >= 11'd16 && rel[i] <= 11'd19)
        rxd_nxt[8*i +: 8] = 8'h00;
    end
  end
`else
  assign rxd_nxt = bus.rxd_i;
`endif

  // Pass-through register, advancing only on enabled cycles
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      bus.rxd_o <= '0;
      bus.rxc_o <= '0;
    end else if (bus.rx_clk_en_i) begin
      bus.rxd_o <= rxd_nxt;
      bus.rxc_o <= bus.rxc_i;
    end
  end

  // Frame tracking FSM with the header shadow registers
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state    <= IDLE;
      mask     <= '0;
      ns_cap   <= '0;
      seq_cap  <= '0;
      type_cap <= '0;
    end else if (bus.rx_clk_en_i) begin
      case (state)
        IDLE: begin
          mask <= '0;
          if (is_start) state <= HDR;
        end
        HDR: begin
          if (is_start) begin
            mask <= '0;
          end else begin
            mask    <= mask | hit;
            ns_cap  <= ns_nxt;
            seq_cap <= seq_nxt;
            if (is_err) begin
              state <= IDLE;
            end else if (mask_full && capture_en) begin
              type_cap <= bus.ptp_messageType_i;
              state    <= is_term ? PUSH : WAIT_EOF;
            end else if (is_term || mask_full) begin
              state <= IDLE;
            end
          end
        end
        WAIT_EOF: begin
          if (is_start) begin
            mask  <= '0;
            state <= HDR;
          end else if (is_err) begin
            state <= IDLE;
          end else if (is_term) begin
            state <= PUSH;
          end
        end
        PUSH: begin
          mask  <= '0;
          state <= is_start ? HDR : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The embedded ns was stamped less than a second ago, so at most one seconds borrow
  assign sec = (ns_cap <= bus.rtc_time_i[31:0]) ? bus.rtc_time_i[79:32]
                                                : bus.rtc_time_i[79:32] - 48'd1;

  assign level    = wr_ptr - rd_ptr;
  assign empty    = (level == '0);
  assign full     = level[FIFO_AW];
  assign pop      = bus.ts_rd_en_i & ~empty;
  assign push_req = bus.rx_clk_en_i & (state == PUSH);
  assign push     = push_req & (~full | pop);

  // Entry storage; read data is masked while empty so no reset is needed here
  always_ff @(posedge rx_clk) begin
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= {type_cap, seq_cap, sec, ns_cap};
  end

  // FIFO pointers and saturating drop counter; pops ignore the clock enable
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push_req && !push && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign bus.ts_empty_o    = empty;
  assign bus.ts_level_o    = level;
  assign bus.ts_data_o     = empty ? '0 : mem[rd_ptr[FIFO_AW-1:0]];
  assign bus.ts_drop_cnt_o = drop_cnt;
endmodule

// File: tb/tb_rx_ext_ts.sv
// Self-checking bench for rx_ext_ts: directed timestamp cases plus randomized frames against a queue model.
// Latency checked: pass-through 1 enabled cycle, entry visible right after the PUSH cycle.
// Backpressure exercised: full FIFO drops, simultaneous push/pop on full and empty, pops with enable low.
`timescale 1ns/1ps
module tb_rx_ext_ts;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int FLEN  = 80;

  logic rx_clk   = 1'b0;
  logic rx_rst_n = 1'b0;

  rx_ext_ts_if #(.FIFO_AW(AW)) bus ();

  rx_ext_ts #(.FIFO_DEPTH(DEPTH), .FIFO_AW(AW)) dut (
    .rx_clk   (rx_clk),
    .rx_rst_n (rx_rst_n),
    .bus      (bus)
  );

  always #5 rx_clk = ~rx_clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [99:0] exp_q[$];
  int          exp_drop = 0;
  logic [7:0]  fb [FLEN];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One enabled word, then maybe a disabled cycle with garbage inputs that must not move the output
  task automatic drive_word(input logic [63:0] d, input logic [7:0] c, input logic [63:0] exp_d, input logic rd);
    bus.rxd_i = d;
    bus.rxc_i = c;
    bus.rx_clk_en_i = 1'b1;
    bus.ts_rd_en_i = rd;
    @(posedge rx_clk); #1;
    bus.ts_rd_en_i = 1'b0;
    check("rxd_o", bus.rxd_o, exp_d);
    check("rxc_o", bus.rxc_o, c);
    if ($urandom_range(0, 3) == 0) begin
      bus.rx_clk_en_i = 1'b0;
      bus.rxd_i = {$urandom, $urandom};
      bus.rxc_i = 8'($urandom);
      @(posedge rx_clk); #1;
      check("rxd_hold", bus.rxd_o, exp_d);
    end
  endtask

  task automatic send_frame(input logic [3:0] typ, input logic [31:0] ns, input logic [15:0] seq,
                            input logic ptp, input logic cfg5, input logic bad_end,
                            input logic [79:0] rtc, input logic pop_at_push, input int nwords);
    int          base;
    logic        qual;
    logic [63:0] d, e;
    logic [47:0] sec;
    base = $urandom_range(14, FLEN - 34);
    qual = cfg5 & ptp & ~typ[3];
    for (int k = 0; k < FLEN; k++) fb[k] = 8'($urandom);
    for (int k = 0; k < 4; k++) fb[base+16+k] = ns[31-8*k -: 8];
    fb[base+30] = seq[15:8];
    fb[base+31] = seq[7:0];
    bus.ptp_messageType_i = typ;
    bus.is_ptp_message_i  = ptp;
    bus.tsu_cfg_i         = {26'($urandom), cfg5, 5'($urandom)};
    bus.ptp_addr_base_i   = 11'(base);
    bus.rtc_time_i        = rtc;
    bus.eth_count_i       = 11'h7F8;
    drive_word({8'hD5, {6{8'h55}}, 8'hFB}, 8'h01, {8'hD5, {6{8'h55}}, 8'hFB}, 1'b0);
    for (int w = 0; w < nwords; w++) begin
      bus.eth_count_i = 11'(8*w);
      for (int i = 0; i < 8; i++) begin
        d[8*i +: 8] = fb[8*w+i];
        e[8*i +: 8] = fb[8*w+i];
`ifdef RX_EXT_TS_CLEAR_EN
        if (qual && (8*w+i) >= base+16 && (8*w+i) <= base+19) e[8*i +: 8] = 8'h00;
`endif
      end
      drive_word(d, 8'h00, e, 1'b0);
    end
    if (nwords < FLEN/8) return;
    if (bad_end) d = {{6{8'h07}}, 8'hFD, 8'hFE};
    else         d = {{7{8'h07}}, 8'hFD};
    bus.eth_count_i = 11'(FLEN);
    drive_word(d, 8'hFF, d, 1'b0);
    check("level_pre_push", bus.ts_level_o, exp_q.size());
    check("empty_pre_push", bus.ts_empty_o, exp_q.size() == 0);
    drive_word({8{8'h07}}, 8'hFF, {8{8'h07}}, pop_at_push);
    if (pop_at_push && exp_q.size() > 0) void'(exp_q.pop_front());
    if (qual && !bad_end) begin
      sec = (ns <= rtc[31:0]) ? rtc[79:32] : rtc[79:32] - 48'd1;
      if (exp_q.size() < DEPTH) exp_q.push_back({typ, seq, sec, ns});
      else if (exp_drop < 65535) exp_drop++;
    end
    check("level", bus.ts_level_o, exp_q.size());
    check("empty", bus.ts_empty_o, exp_q.size() == 0);
    check("drop", bus.ts_drop_cnt_o, exp_drop);
  endtask

  task automatic pop_check(input string tag);
    bus.rxd_i = {8{8'h07}};
    bus.rxc_i = 8'hFF;
    bus.rx_clk_en_i = 1'($urandom);
    if (exp_q.size() > 0) check({tag, "_data"}, bus.ts_data_o, exp_q[0]);
    bus.ts_rd_en_i = 1'b1;
    @(posedge rx_clk); #1;
    bus.ts_rd_en_i = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    check({tag, "_level"}, bus.ts_level_o, exp_q.size());
    check({tag, "_empty"}, bus.ts_empty_o, exp_q.size() == 0);
  endtask

  initial begin
    logic [79:0] rtc;
    bus.rx_clk_en_i = 1'b1;
    bus.rxd_i = '1;
    bus.rxc_i = 8'h00;
    bus.rtc_time_i = '0;
    bus.tsu_cfg_i = '0;
    bus.eth_count_i = '0;
    bus.ptp_addr_base_i = '0;
    bus.ptp_messageType_i = '0;
    bus.is_ptp_message_i = 1'b0;
    bus.ts_rd_en_i = 1'b0;

    // Reset values while the clock runs with enable high
    repeat (3) @(posedge rx_clk);
    #1;
    check("rst_rxd", bus.rxd_o, 64'd0);
    check("rst_rxc", bus.rxc_o, 8'd0);
    check("rst_empty", bus.ts_empty_o, 1'b1);
    check("rst_data", bus.ts_data_o, 100'd0);
    check("rst_level", bus.ts_level_o, 4'd0);
    check("rst_drop", bus.ts_drop_cnt_o, 16'd0);
    @(negedge rx_clk) rx_rst_n = 1'b1;

    // Sync frame, RTC ns ahead of the captured ns
    send_frame(4'd0, 32'h1234_5678, 16'h00A5, 1'b1, 1'b1, 1'b0, {48'd100, 32'h2000_0000}, 1'b0, FLEN/8);
    check("sync_entry", bus.ts_data_o, {4'd0, 16'h00A5, 48'd100, 32'h1234_5678});
    pop_check("sync");

    // RTC ns wrapped since the stamp: borrow one second
    send_frame(4'd0, 32'h1234_5678, 16'h00A5, 1'b1, 1'b1, 1'b0, {48'd100, 32'h0000_0100}, 1'b0, FLEN/8);
    check("wrap_entry", bus.ts_data_o, {4'd0, 16'h00A5, 48'd99, 32'h1234_5678});
    pop_check("wrap");

    // Seconds borrow at zero wraps to all ones; equal ns does not borrow
    send_frame(4'd1, 32'h0000_0001, 16'h7777, 1'b1, 1'b1, 1'b0, {48'd0, 32'd0}, 1'b0, FLEN/8);
    check("sec0_entry", bus.ts_data_o, {4'd1, 16'h7777, 48'hFFFF_FFFF_FFFF, 32'h1});
    pop_check("sec0");
    send_frame(4'd3, 32'h3B9A_C9FF, 16'h1111, 1'b1, 1'b1, 1'b0, {48'd5, 32'h3B9A_C9FF}, 1'b0, FLEN/8);
    check("eq_entry", bus.ts_data_o, {4'd3, 16'h1111, 48'd5, 32'h3B9A_C9FF});
    pop_check("eq");

    // Non-qualified frames never push
    send_frame(4'd8, 32'hAAAA_0000, 16'h0001, 1'b1, 1'b1, 1'b0, {48'd9, 32'hF000_0000}, 1'b0, FLEN/8);
    check("fu_level", bus.ts_level_o, 4'd0);
    send_frame(4'd0, 32'hAAAA_0000, 16'h0002, 1'b1, 1'b0, 1'b0, {48'd9, 32'hF000_0000}, 1'b0, FLEN/8);
    check("cfg_off_level", bus.ts_level_o, 4'd0);
    send_frame(4'd0, 32'hAAAA_0000, 16'h0003, 1'b0, 1'b1, 1'b0, {48'd9, 32'hF000_0000}, 1'b0, FLEN/8);
    check("not_ptp_level", bus.ts_level_o, 4'd0);
    pop_check("empty_pop");

    // Push with pop on an empty FIFO: pop ignored, entry lands
    send_frame(4'd2, $urandom, 16'h0042, 1'b1, 1'b1, 1'b0, {48'd7, 32'hFFFF_FFFF}, 1'b1, FLEN/8);
    check("empty_pp_level", bus.ts_level_o, 4'd1);
    pop_check("empty_pp");

    // Overfill by two
    for (int k = 0; k < DEPTH + 2; k++)
      send_frame(4'(k % 4), $urandom, 16'(16'h0100 + k), 1'b1, 1'b1, 1'b0,
                 {16'($urandom), $urandom, $urandom}, 1'b0, FLEN/8);
    check("full_level", bus.ts_level_o, 4'd8);
    check("full_drop", bus.ts_drop_cnt_o, 16'd2);
    check("full_head_seq", bus.ts_data_o[95:80], 16'h0100);

    // Push with pop while full: both succeed, no drop
    send_frame(4'd1, $urandom, 16'h0BBB, 1'b1, 1'b1, 1'b0, {16'($urandom), $urandom, $urandom}, 1'b1, FLEN/8);
    check("full_pp_level", bus.ts_level_o, 4'd8);
    check("full_pp_drop", bus.ts_drop_cnt_o, 16'd2);
    while (exp_q.size() > 0) pop_check("drain_full");

    // Error-terminated frame is discarded, the next one is kept
    send_frame(4'd0, $urandom, 16'h0E0E, 1'b1, 1'b1, 1'b1, {16'($urandom), $urandom, $urandom}, 1'b0, FLEN/8);
    check("err_level", bus.ts_level_o, 4'd0);
    send_frame(4'd0, $urandom, 16'h0E0F, 1'b1, 1'b1, 1'b0, {16'($urandom), $urandom, $urandom}, 1'b0, FLEN/8);
    check("after_err_level", bus.ts_level_o, 4'd1);
    pop_check("after_err");

    // Start mid-header restarts capture; only the second frame is recorded
    send_frame(4'd0, 32'hDEAD_BEEF, 16'h0D0D, 1'b1, 1'b1, 1'b0, {48'd1, 32'hFFFF_FFFF}, 1'b0, 5);
    send_frame(4'd0, 32'h0000_0010, 16'h0C0C, 1'b1, 1'b1, 1'b0, {48'd2, 32'h0000_0020}, 1'b0, FLEN/8);
    check("restart_entry", bus.ts_data_o, {4'd0, 16'h0C0C, 48'd2, 32'h10});
    pop_check("restart");

    // Reset in the middle of a frame with entries and drops recorded
    for (int k = 0; k < DEPTH + 1; k++)
      send_frame(4'd0, $urandom, 16'($urandom), 1'b1, 1'b1, 1'b0, {16'($urandom), $urandom, $urandom}, 1'b0, FLEN/8);
    send_frame(4'd0, $urandom, 16'h5555, 1'b1, 1'b1, 1'b0, {16'($urandom), $urandom, $urandom}, 1'b0, 4);
    #2 rx_rst_n = 1'b0;
    #2;
    check("midrst_level", bus.ts_level_o, 4'd0);
    check("midrst_empty", bus.ts_empty_o, 1'b1);
    check("midrst_drop", bus.ts_drop_cnt_o, 16'd0);
    check("midrst_rxd", bus.rxd_o, 64'd0);
    exp_q.delete();
    exp_drop = 0;
    @(negedge rx_clk) rx_rst_n = 1'b1;
    send_frame(4'd0, $urandom, 16'h6666, 1'b1, 1'b1, 1'b0, {16'($urandom), $urandom, $urandom}, 1'b0, FLEN/8);
    check("postrst_level", bus.ts_level_o, 4'd1);
    pop_check("postrst");

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      rtc = {16'($urandom), $urandom, $urandom};
      send_frame(4'($urandom), $urandom, 16'($urandom),
                 $urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0, $urandom_range(0, 6) == 0,
                 rtc, 1'($urandom), FLEN/8);
      for (int p = $urandom_range(0, 2); p > 0; p--) pop_check("rnd");
    end
    while (exp_q.size() > 0) pop_check("drain_rnd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
